// File: rtl/dram_req_sched_if.sv
// dram_req_sched_if
//   Bundles the host request channel and the controller command channel of
//   the DRAM request scheduler.
//   slave  : the scheduler side (accepts req_*, drives ctl_* and ref_overflow)
//   master : the environment side (host + controller FSM, or a testbench)
//   Host channel : req_valid, req_ready, req_write, req_addr, req_wdata
//   Ctl channel  : ctl_valid, ctl_ready, ctl_op, ctl_row_hit, ctl_need_pre,
//                  ctl_rank, ctl_bg, ctl_bank, ctl_row, ctl_col, ctl_offset,
//                  ctl_wdata
//   Status       : ref_overflow (sticky lost-refresh flag)
interface dram_req_sched_if #(
  parameter int ADDR_W = 33
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;

  logic              ctl_valid;
  logic              ctl_ready;
  logic [1:0]        ctl_op;
  logic              ctl_row_hit;
  logic              ctl_need_pre;
  logic              ctl_rank;
  logic [1:0]        ctl_bg;
  logic [1:0]        ctl_bank;
  logic [14:0]       ctl_row;
  logic [9:0]        ctl_col;
  logic [1:0]        ctl_offset;
  logic [63:0]       ctl_wdata;

  logic              ref_overflow;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, ctl_ready,
    output req_ready, ctl_valid, ctl_op, ctl_row_hit, ctl_need_pre,
           ctl_rank, ctl_bg, ctl_bank, ctl_row, ctl_col, ctl_offset,
           ctl_wdata, ref_overflow
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, ctl_ready,
    input  req_ready, ctl_valid, ctl_op, ctl_row_hit, ctl_need_pre,
           ctl_rank, ctl_bg, ctl_bank, ctl_row, ctl_col, ctl_offset,
           ctl_wdata, ref_overflow
  );
endinterface

// File: rtl/dram_req_sched.sv
// dram_req_sched
//   Request scheduler in front of the DRAM controller FSM. Host requests are
//   buffered in a small FIFO; the head entry (or a refresh) is latched into a
//   command register, tagged hit / miss / conflict against a per-bank open-row
//   table, and held until the controller takes it.
//   Ports:
//     CLK, RST : clock and synchronous active-high reset
//     bus      : dram_req_sched_if.slave (host request + controller command)
//   Optional feature macro DRAM_SCHED_PERF_EN adds saturating 32-bit
//   counters perf_hits, perf_misses, perf_conflicts, perf_refs.
//   Address map: [0] ignored, [2:1] offset, [12:3] col, [14:13] bank,
//                [16:15] bg, [17] rank, [32:18] row.
module dram_req_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 33,
  parameter int T_REFI     = 250,
  parameter int REF_MAX    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  dram_req_sched_if.slave  bus
`ifdef DRAM_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_hits,
  output logic [31:0]      perf_misses,
  output logic [31:0]      perf_conflicts,
  output logic [31:0]      perf_refs
`endif
);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int REFI_W = $clog2(T_REFI);
  localparam int PEND_W = $clog2(REF_MAX + 1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_REF   = 2'b10;

  typedef enum logic {ST_SELECT, ST_HOLD} state_t;

  // Request FIFO storage; bit 0 of the address is never stored.
  logic              mem_write [FIFO_DEPTH];
  logic [ADDR_W-1:1] mem_addr  [FIFO_DEPTH];
  logic [63:0]       mem_wdata [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [REFI_W-1:0] refi_cnt_reg;
  logic [PEND_W-1:0] pending_reg;
  logic              ref_overflow_reg;
  state_t            state_reg;

  logic              ctl_valid_reg, ctl_row_hit_reg, ctl_need_pre_reg, ctl_rank_reg;
  logic [1:0]        ctl_op_reg, ctl_bg_reg, ctl_bank_reg, ctl_offset_reg;
  logic [14:0]       ctl_row_reg;
  logic [9:0]        ctl_col_reg;
  logic [63:0]       ctl_wdata_reg;

  logic              unused_addr_bit;
  assign unused_addr_bit = bus.req_addr[0];

  logic full, empty, push, xfer, pop, tick, ref_acc, ref_sel, any_open;
  assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign push    = bus.req_valid && !full;
  assign xfer    = ctl_valid_reg && bus.ctl_ready;
  // The head entry stays in the FIFO while it is being presented and is
  // only released when the controller takes it.
  assign pop     = xfer && (ctl_op_reg != OP_REF);
  assign ref_acc = xfer && (ctl_op_reg == OP_REF);
  assign tick    = (refi_cnt_reg == REFI_W'(T_REFI - 1));
  assign ref_sel = (pending_reg == PEND_W'(REF_MAX)) || ((pending_reg != '0) && empty);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_write[wr_ptr_reg] <= bus.req_write;
      mem_addr[wr_ptr_reg]  <= bus.req_addr[ADDR_W-1:1];
      mem_wdata[wr_ptr_reg] <= bus.req_wdata;
    end
  end

  // Head decode
  logic              head_write;
  logic [ADDR_W-1:1] head_addr;
  logic [3:0]        head_idx;
  logic [3:0]        ctl_idx;
  assign head_write = mem_write[rd_ptr_reg];
  assign head_addr  = mem_addr[rd_ptr_reg];
  assign head_idx   = {head_addr[17], head_addr[16:15], head_addr[14:13]};
  assign ctl_idx    = {ctl_rank_reg, ctl_bg_reg, ctl_bank_reg};

  // Open-row table, one entry per {rank, bg, bank}. Updated only when a
  // command is taken, so a held command always sees a stable table.
  logic [15:0] open_vec;
  logic [14:0] row_tab [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_bank
    logic        open_reg;
    logic [14:0] row_reg;
    always_ff @(posedge CLK) begin
      if (RST) begin
        open_reg <= 1'b0;
        row_reg  <= '0;
      end else if (xfer) begin
        if (ctl_op_reg == OP_REF) begin
          open_reg <= 1'b0;
        end else if (ctl_idx == 4'(gi)) begin
          open_reg <= 1'b1;
          row_reg  <= ctl_row_reg;
        end
      end
    end
    assign open_vec[gi] = open_reg;
    assign row_tab[gi]  = row_reg;
  end

  logic head_open, head_hit;
  assign any_open  = |open_vec;
  assign head_open = open_vec[head_idx];
  assign head_hit  = head_open && (row_tab[head_idx] == head_addr[32:18]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      refi_cnt_reg     <= '0;
      pending_reg      <= '0;
      ref_overflow_reg <= 1'b0;
      state_reg        <= ST_SELECT;
      ctl_valid_reg    <= 1'b0;
      ctl_op_reg       <= OP_READ;
      ctl_row_hit_reg  <= 1'b0;
      ctl_need_pre_reg <= 1'b0;
      ctl_rank_reg     <= 1'b0;
      ctl_bg_reg       <= '0;
      ctl_bank_reg     <= '0;
      ctl_row_reg      <= '0;
      ctl_col_reg      <= '0;
      ctl_offset_reg   <= '0;
      ctl_wdata_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      refi_cnt_reg <= tick ? '0 : refi_cnt_reg + 1'b1;

      // A tick and a refresh accept in the same cycle cancel out.
      if (tick && !ref_acc) begin
        if (pending_reg == PEND_W'(REF_MAX)) ref_overflow_reg <= 1'b1;
        else                                  pending_reg      <= pending_reg + 1'b1;
      end else if (!tick && ref_acc) begin
        pending_reg <= pending_reg - 1'b1;
      end

      case (state_reg)
        ST_SELECT: begin
          if (ref_sel) begin
            state_reg        <= ST_HOLD;
            ctl_valid_reg    <= 1'b1;
            ctl_op_reg       <= OP_REF;
            ctl_row_hit_reg  <= 1'b0;
            ctl_need_pre_reg <= any_open;
            ctl_rank_reg     <= 1'b0;
            ctl_bg_reg       <= '0;
            ctl_bank_reg     <= '0;
            ctl_row_reg      <= '0;
            ctl_col_reg      <= '0;
            ctl_offset_reg   <= '0;
            ctl_wdata_reg    <= '0;
          end else if (!empty) begin
            state_reg        <= ST_HOLD;
            ctl_valid_reg    <= 1'b1;
            ctl_op_reg       <= head_write ? OP_WRITE : OP_READ;
            ctl_row_hit_reg  <= head_hit;
            ctl_need_pre_reg <= head_open && !head_hit;
            ctl_rank_reg     <= head_addr[17];
            ctl_bg_reg       <= head_addr[16:15];
            ctl_bank_reg     <= head_addr[14:13];
            ctl_row_reg      <= head_addr[32:18];
            ctl_col_reg      <= head_addr[12:3];
            ctl_offset_reg   <= head_addr[2:1];
            ctl_wdata_reg    <= mem_wdata[rd_ptr_reg];
          end
        end
        ST_HOLD: begin
          if (bus.ctl_ready) begin
            state_reg     <= ST_SELECT;
            ctl_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_SELECT;
      endcase
    end
  end

  assign bus.req_ready    = !full;
  assign bus.ctl_valid    = ctl_valid_reg;
  assign bus.ctl_op       = ctl_op_reg;
  assign bus.ctl_row_hit  = ctl_row_hit_reg;
  assign bus.ctl_need_pre = ctl_need_pre_reg;
  assign bus.ctl_rank     = ctl_rank_reg;
  assign bus.ctl_bg       = ctl_bg_reg;
  assign bus.ctl_bank     = ctl_bank_reg;
  assign bus.ctl_row      = ctl_row_reg;
  assign bus.ctl_col      = ctl_col_reg;
  assign bus.ctl_offset   = ctl_offset_reg;
  assign bus.ctl_wdata    = ctl_wdata_reg;
  assign bus.ref_overflow = ref_overflow_reg;

`ifdef DRAM_SCHED_PERF_EN
  logic [31:0] perf_hits_reg, perf_misses_reg, perf_conflicts_reg, perf_refs_reg;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_hits_reg      <= '0;
      perf_misses_reg    <= '0;
      perf_conflicts_reg <= '0;
      perf_refs_reg      <= '0;
    end else if (xfer) begin
      if (ctl_op_reg == OP_REF)  perf_refs_reg      <= sat_inc(perf_refs_reg);
      else if (ctl_row_hit_reg)  perf_hits_reg      <= sat_inc(perf_hits_reg);
      else if (ctl_need_pre_reg) perf_conflicts_reg <= sat_inc(perf_conflicts_reg);
      else                       perf_misses_reg    <= sat_inc(perf_misses_reg);
    end
  end

  assign perf_hits      = perf_hits_reg;
  assign perf_misses    = perf_misses_reg;
  assign perf_conflicts = perf_conflicts_reg;
  assign perf_refs      = perf_refs_reg;
`endif
endmodule

// File: tb/tb_dram_req_sched.sv
// tb_dram_req_sched
//   Directed vector table for address decode and hit/miss/conflict tagging,
//   hand sequences for stall, refresh, overflow and mid-operation reset, and a
//   randomized phase. A transaction-level scoreboard (request queue plus an
//   open-row map per bank) checks every command the controller takes.
module tb_dram_req_sched;
  localparam int T_REFI = 250;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_req_sched_if bus ();

`ifdef DRAM_SCHED_PERF_EN
  logic [31:0] perf_hits, perf_misses, perf_conflicts, perf_refs;
`endif

  dram_req_sched dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
`ifdef DRAM_SCHED_PERF_EN
    ,
    .perf_hits      (perf_hits),
    .perf_misses    (perf_misses),
    .perf_conflicts (perf_conflicts),
    .perf_refs      (perf_refs)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] mk_addr(input logic [14:0] row, input logic rank,
                                          input logic [1:0] bg, input logic [1:0] bank,
                                          input logic [9:0] col, input logic [1:0] off,
                                          input logic ign);
    return {row, rank, bg, bank, col, off, ign};
  endfunction

  function automatic logic [99:0] snap();
    return {bus.ctl_op, bus.ctl_row_hit, bus.ctl_need_pre, bus.ctl_rank, bus.ctl_bg,
            bus.ctl_bank, bus.ctl_row, bus.ctl_col, bus.ctl_offset, bus.ctl_wdata};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        write;
    logic [32:0] addr;
    logic [63:0] wdata;
  } req_t;

  req_t        exp_q[$];
  int          op_log[$];
  logic        model_open [16];
  logic [14:0] model_row  [16];
  int          cyc  = 0;
  int          refs = 0;
  bit          prev_hold = 1'b0;
  logic [99:0] held = '0;

  always @(negedge clk) begin : mon
    req_t        e;
    logic [3:0]  idx;
    logic [14:0] row;
    logic        any, e_hit, e_pre;
    if (rst) begin
      exp_q.delete();
      op_log.delete();
      for (int i = 0; i < 16; i++) begin
        model_open[i] = 1'b0;
        model_row[i]  = '0;
      end
      cyc = 0;
      refs = 0;
      prev_hold = 1'b0;
    end else begin
      cyc++;
      if (prev_hold) begin
        check("hold_valid", bus.ctl_valid, 1'b1);
        check("hold_stable", snap(), held);
      end
      if (bus.req_valid && bus.req_ready)
        exp_q.push_back('{bus.req_write, bus.req_addr, bus.req_wdata});
      if (bus.ctl_valid && bus.ctl_ready) begin
        op_log.push_back(int'(bus.ctl_op));
        if (bus.ctl_op == 2'b10) begin
          any = 1'b0;
          for (int i = 0; i < 16; i++) any |= model_open[i];
          check("ref_need_pre", bus.ctl_need_pre, any);
          check("ref_row_hit", bus.ctl_row_hit, 1'b0);
          check("ref_fields", {bus.ctl_rank, bus.ctl_bg, bus.ctl_bank, bus.ctl_row,
                               bus.ctl_col, bus.ctl_offset, bus.ctl_wdata}, '0);
          refs++;
          check("ref_rate", (refs * T_REFI <= cyc), 1'b1);
          for (int i = 0; i < 16; i++) model_open[i] = 1'b0;
          $display("[TB] cyc=%0d take REFRESH need_pre=%0d", cyc, bus.ctl_need_pre);
        end else if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_cmd: got op %0d expected no command", bus.ctl_op);
        end else begin
          e     = exp_q.pop_front();
          idx   = {e.addr[17], e.addr[16:15], e.addr[14:13]};
          row   = e.addr[32:18];
          e_hit = model_open[idx] && (model_row[idx] == row);
          e_pre = model_open[idx] && !e_hit;
          check("cmd", snap(), {(e.write ? 2'b01 : 2'b00), e_hit, e_pre, e.addr[17],
                                e.addr[16:15], e.addr[14:13], row, e.addr[12:3],
                                e.addr[2:1], e.wdata});
          model_open[idx] = 1'b1;
          model_row[idx]  = row;
          $display("[TB] cyc=%0d take op=%0d bank=%0d row=%0h hit=%0d pre=%0d",
                   cyc, bus.ctl_op, idx, bus.ctl_row, bus.ctl_row_hit, bus.ctl_need_pre);
        end
      end
      prev_hold = bus.ctl_valid && !bus.ctl_ready;
      held      = snap();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.ctl_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic w, input logic [32:0] a, input logic [63:0] d);
    bit ok;
    step();
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("push_accepted", ok, 1'b1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok, output bit first_seen);
    ok = 1'b0;
    first_seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (bus.ctl_valid) begin
        ok = 1'b1;
        first_seen = (k == 0);
        break;
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 5000 && cyc < target; k++) @(negedge clk);
  endtask

  task automatic wait_ops(input int n);
    for (int k = 0; k < 300 && op_log.size() < n; k++) @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        write;
    logic [14:0] row;
    logic        rank;
    logic [1:0]  bg;
    logic [1:0]  bank;
    logic [9:0]  col;
    logic [1:0]  off;
    logic        ign;
    logic [63:0] wdata;
    logic        hit;
    logic        pre;
  } vec_t;

  initial begin : main
    vec_t        vecs[8];
    bit          ok, first;
    int          nvalid, t_ref;
    int          exp_ops[12];
    logic [99:0] snap0;

    vecs[0] = '{1'b0, 15'd5,      1'b0, 2'd0, 2'd1, 10'd0,     2'd0, 1'b0, 64'h0,                  1'b0, 1'b0};
    vecs[1] = '{1'b0, 15'd5,      1'b0, 2'd0, 2'd1, 10'd17,    2'd1, 1'b0, 64'h0,                  1'b1, 1'b0};
    vecs[2] = '{1'b0, 15'd9,      1'b0, 2'd0, 2'd1, 10'd33,    2'd2, 1'b0, 64'h0,                  1'b0, 1'b1};
    vecs[3] = '{1'b1, 15'h7ABC,   1'b1, 2'd3, 2'd2, 10'h3FF,   2'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 15'h7ABC,   1'b1, 2'd3, 2'd2, 10'h155,   2'd0, 1'b1, 64'hA5A5_5A5A_FFFF_0000, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 15'd9,      1'b0, 2'd0, 2'd1, 10'h2AA,   2'd1, 1'b0, 64'h0,                  1'b1, 1'b0};
    vecs[6] = '{1'b0, 15'd9,      1'b0, 2'd1, 2'd1, 10'd1,     2'd0, 1'b0, 64'h0,                  1'b0, 1'b0};
    vecs[7] = '{1'b0, 15'd0,      1'b1, 2'd3, 2'd2, 10'd2,     2'd3, 1'b1, 64'h0,                  1'b0, 1'b1};
    exp_ops = '{0, 2, 0, 0, 0, 2, 2, 2, 2, 2, 2, 2};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_ctl_valid", bus.ctl_valid, 1'b0);
    check("rst_outputs", snap(), '0);
    check("rst_overflow", bus.ref_overflow, 1'b0);

    // Decode and hit/miss/conflict table
    step();
    bus.ctl_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].write, mk_addr(vecs[i].row, vecs[i].rank, vecs[i].bg, vecs[i].bank,
                                  vecs[i].col, vecs[i].off, vecs[i].ign), vecs[i].wdata);
      wait_valid(10, ok, first);
      check("vec_valid", ok, 1'b1);
      check("vec_latency", first, 1'b0);
      check("vec_op", bus.ctl_op, vecs[i].write ? 2'b01 : 2'b00);
      check("vec_fields", {bus.ctl_rank, bus.ctl_bg, bus.ctl_bank, bus.ctl_row, bus.ctl_col, bus.ctl_offset},
            {vecs[i].rank, vecs[i].bg, vecs[i].bank, vecs[i].row, vecs[i].col, vecs[i].off});
      check("vec_hit", bus.ctl_row_hit, vecs[i].hit);
      check("vec_pre", bus.ctl_need_pre, vecs[i].pre);
      check("vec_wdata", bus.ctl_wdata, vecs[i].wdata);
    end

    // Stall: FIFO fills, outputs frozen, drain in order
    do_reset();
    for (int i = 0; i < 4; i++)
      push(i[0], mk_addr(15'(i + 1), 1'b0, 2'd0, 2'(i), 10'(i), 2'd0, 1'b0), 64'(i + 100));
    @(negedge clk);
    check("full_ready", bus.req_ready, 1'b0);
    check("stall_valid", bus.ctl_valid, 1'b1);
    snap0 = snap();
    step();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = mk_addr(15'd77, 1'b1, 2'd1, 2'd1, 10'd5, 2'd1, 1'b0);
    bus.req_wdata = 64'd555;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("stall_full", bus.req_ready, 1'b0);
      check("stall_frozen", snap(), snap0);
    end
    step();
    bus.ctl_ready = 1'b1;
    for (int k = 0; k < 50 && !bus.req_ready; k++) @(negedge clk);
    step();
    bus.req_valid = 1'b0;
    wait_ops(5);
    check("drain_count", op_log.size(), 5);

    // Idle refresh
    do_reset();
    step();
    bus.ctl_ready = 1'b1;
    push(1'b0, mk_addr(15'd5, 1'b0, 2'd0, 2'd1, 10'd0, 2'd0, 1'b0), 64'h0);
    ok = 1'b0;
    t_ref = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.ctl_valid && bus.ctl_op == 2'b10) begin
        ok = 1'b1;
        t_ref = cyc;
        break;
      end
    end
    check("ref_seen", ok, 1'b1);
    check("ref_time", (t_ref >= T_REFI) && (t_ref <= T_REFI + 4), 1'b1);
    check("ref_pre_open", bus.ctl_need_pre, 1'b1);
    push(1'b0, mk_addr(15'd5, 1'b0, 2'd0, 2'd1, 10'd0, 2'd0, 1'b0), 64'h0);
    wait_valid(10, ok, first);
    check("post_ref_valid", ok, 1'b1);
    check("post_ref_op", bus.ctl_op, 2'b00);
    check("post_ref_pre", bus.ctl_need_pre, 1'b0);
    check("post_ref_hit", bus.ctl_row_hit, 1'b0);
    step();
    nvalid = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.ctl_valid) nvalid++;
    end
    check("pending_cleared", nvalid, 0);

    // Long stall: pending saturates, overflow, refresh beats queued reads
    do_reset();
    for (int i = 0; i < 4; i++)
      push(1'b0, mk_addr(15'(i + 3), 1'b0, 2'd2, 2'(i), 10'd0, 2'd0, 1'b0), 64'h0);
    wait_cyc(8 * T_REFI + 200);
    check("ovf_before", bus.ref_overflow, 1'b0);
    wait_cyc(9 * T_REFI + 6);
    check("ovf_set", bus.ref_overflow, 1'b1);
    step();
    bus.ctl_ready = 1'b1;
    wait_ops(12);
    check("sat_op_count", op_log.size(), 12);
    for (int i = 0; i < 12 && i < op_log.size(); i++)
      check("sat_op_order", op_log[i], exp_ops[i]);
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.ctl_valid) nvalid++;
    end
    check("sat_drained", nvalid, 0);
    check("ovf_sticky", bus.ref_overflow, 1'b1);

    // Reset mid-operation
    do_reset();
    wait_cyc(T_REFI + 10);
    push(1'b0, mk_addr(15'd1, 1'b0, 2'd0, 2'd0, 10'd0, 2'd0, 1'b0), 64'h0);
    push(1'b1, mk_addr(15'd2, 1'b0, 2'd0, 2'd1, 10'd0, 2'd0, 1'b0), 64'h1);
    @(negedge clk);
    check("pre_rst_valid", bus.ctl_valid, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", bus.ctl_valid, 1'b0);
    check("mid_rst_ready", bus.req_ready, 1'b1);
    check("mid_rst_outputs", snap(), '0);
    step();
    bus.ctl_ready = 1'b1;
    nvalid = 0;
    for (int k = 0; k < T_REFI - 15; k++) begin
      @(negedge clk);
      if (bus.ctl_valid) nvalid++;
    end
    check("mid_rst_idle", nvalid, 0);

    // Randomized traffic against the scoreboard
    do_reset();
    for (int k = 0; k < 800; k++) begin
      step();
      bus.req_valid = ($urandom_range(0, 1) == 1);
      bus.req_write = ($urandom_range(0, 1) == 1);
      bus.req_addr  = mk_addr(15'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'd0,
                              2'($urandom_range(0, 1)), 10'($urandom), 2'($urandom), 1'($urandom));
      bus.req_wdata = {$urandom, $urandom};
      bus.ctl_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    bus.req_valid = 1'b0;
    bus.ctl_ready = 1'b1;
    for (int k = 0; k < 300 && (exp_q.size() != 0 || bus.ctl_valid); k++) @(negedge clk);
    check("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
